// File: rtl/rx_sweep_ctrl.sv
// RX frequency-sweep scheduler: retune, settle, integrate magnitude, emit one result per step.
// Define RX_SWEEP_PHASE_EN to add the res_phase output captured at the last integrated strobe.
module rx_sweep_ctrl #(
    parameter int PW = 24,
    parameter int MW = 16,
    parameter int NW = 16,
    parameter int SW = 12,
    parameter int AW = 28
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] start_inc,
    input  logic [PW-1:0] step_inc,
    input  logic [NW-1:0] num_steps,
    input  logic [SW-1:0] settle_cnt,
    input  logic [SW-1:0] avg_cnt,
    input  logic          ce_down,
    input  logic [MW-1:0] rx_magnitude,
    input  logic [24:0]   rx_phase,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [NW-1:0] res_index,
    output logic [AW-1:0] res_mag_sum,
`ifdef RX_SWEEP_PHASE_EN
    output logic [24:0]   res_phase,
`endif
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TUNE,
        S_SETTLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cur_inc_q, cur_inc_d;
    logic [PW-1:0] step_q, step_d;
    logic [NW-1:0] nsteps_q, nsteps_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [SW-1:0] avg_q, avg_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [PW-1:0] pinc_q, pinc_d;
    logic [AW-1:0] mag_ext;

    // Negative magnitudes contribute nothing to the integral.
    assign mag_ext = rx_magnitude[MW-1] ? '0 : AW'(rx_magnitude);

`ifdef RX_SWEEP_PHASE_EN
    logic [24:0] phase_q, phase_d;
`else
    logic rx_phase_unused;
    assign rx_phase_unused = ^rx_phase;
`endif

    always_comb begin
        state_d   = state_q;
        cur_inc_d = cur_inc_q;
        step_d    = step_q;
        nsteps_d  = nsteps_q;
        settle_d  = settle_q;
        avg_d     = avg_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        pinc_d    = pinc_q;
`ifdef RX_SWEEP_PHASE_EN
        phase_d   = phase_q;
`endif
        if (abort && state_q != S_IDLE) begin
            // Abort discards any same-cycle progress, including a handshake.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        cur_inc_d = start_inc;
                        step_d    = step_inc;
                        nsteps_d  = num_steps;
                        settle_d  = settle_cnt;
                        avg_d     = (avg_cnt == '0) ? SW'(1) : avg_cnt;
                        idx_d     = '0;
                        state_d   = (num_steps == '0) ? S_DONE : S_TUNE;
                    end
                end
                S_TUNE: begin
                    pinc_d  = cur_inc_q;
                    cnt_d   = settle_q;
                    acc_d   = '0;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == '0 || (ce_down && cnt_q == SW'(1))) begin
                        cnt_d   = avg_q;
                        state_d = S_ACCUM;
                    end else if (ce_down) begin
                        cnt_d = cnt_q - SW'(1);
                    end
                end
                S_ACCUM: begin
                    if (ce_down) begin
                        acc_d = acc_q + mag_ext;
                        cnt_d = cnt_q - SW'(1);
                        if (cnt_q == SW'(1)) begin
                            state_d = S_EMIT;
`ifdef RX_SWEEP_PHASE_EN
                            phase_d = rx_phase;
`endif
                        end
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        if (idx_q == nsteps_q - NW'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d     = idx_q + NW'(1);
                            cur_inc_d = cur_inc_q + step_q;
                            state_d   = S_TUNE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_inc_q <= '0;
            step_q    <= '0;
            nsteps_q  <= '0;
            settle_q  <= '0;
            avg_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            pinc_q    <= '0;
`ifdef RX_SWEEP_PHASE_EN
            phase_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_inc_q <= cur_inc_d;
            step_q    <= step_d;
            nsteps_q  <= nsteps_d;
            settle_q  <= settle_d;
            avg_q     <= avg_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            pinc_q    <= pinc_d;
`ifdef RX_SWEEP_PHASE_EN
            phase_q   <= phase_d;
`endif
        end
    end

    assign phase_inc   = pinc_q;
    assign busy        = (state_q == S_TUNE) || (state_q == S_SETTLE) ||
                         (state_q == S_ACCUM) || (state_q == S_EMIT);
    assign res_valid   = (state_q == S_EMIT);
    assign res_index   = idx_q;
    assign res_mag_sum = acc_q;
    assign done        = (state_q == S_DONE);
`ifdef RX_SWEEP_PHASE_EN
    assign res_phase   = phase_q;
`endif

endmodule

// File: tb/tb_rx_sweep_ctrl.sv
// Self-checking bench for rx_sweep_ctrl: randomized strobes/magnitudes against a
// per-step model (discard settle strobes, sum clamped next avg strobes).
module tb_rx_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] start_inc = '0;
    logic [23:0] step_inc = '0;
    logic [15:0] num_steps = '0;
    logic [11:0] settle_cnt = '0;
    logic [11:0] avg_cnt = '0;
    logic        ce_down = 1'b0;
    logic [15:0] rx_magnitude = '0;
    logic [24:0] rx_phase = '0;
    logic [23:0] phase_inc;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_index;
    logic [27:0] res_mag_sum;
    logic        done;
`ifdef RX_SWEEP_PHASE_EN
    logic [24:0] res_phase;
`endif

    int checks = 0;
    int errors = 0;
    int alt_cnt = 0;
    logic [23:0] last_inc = '0;

    always #5 sys_clk = ~sys_clk;

    rx_sweep_ctrl dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort),
        .start_inc(start_inc), .step_inc(step_inc), .num_steps(num_steps),
        .settle_cnt(settle_cnt), .avg_cnt(avg_cnt), .ce_down(ce_down),
        .rx_magnitude(rx_magnitude), .rx_phase(rx_phase),
        .phase_inc(phase_inc), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_index(res_index), .res_mag_sum(res_mag_sum),
`ifdef RX_SWEEP_PHASE_EN
        .res_phase(res_phase),
`endif
        .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [23:0] exp_inc);
        check({tag, "_phase_inc"}, phase_inc, exp_inc);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // abort_mode: 0 none, 1 abort during SETTLE of abort_step, 2 abort with handshake in EMIT
    task automatic run_sweep(input logic [23:0] s_inc, input logic [23:0] st_inc,
                             input logic [15:0] n, input logic [11:0] st, input logic [11:0] av,
                             input int mag_mode, input int hold_max, input bit toggle_hold,
                             input int abort_mode, input int abort_step);
        int avg_eff;
        logic [23:0] exp_inc;
        avg_eff = (av == 0) ? 1 : int'(av);
        start_inc = s_inc; step_inc = st_inc; num_steps = n;
        settle_cnt = st; avg_cnt = av;
        start = 1'b1;
        tick;
        start = 1'b0;
        // Later config changes must not affect the running sweep.
        start_inc = 24'($urandom); step_inc = 24'($urandom);
        num_steps = 16'($urandom); settle_cnt = 12'($urandom); avg_cnt = 12'($urandom);
        check("busy_after_start", busy, 1);
        for (int k = 0; k < int'(n); k++) begin
            int mags[$];
            logic [24:0] phs[$];
            int to, mag, hold;
            longint sum;
            bit stable;
            exp_inc = 24'(s_inc + 24'(k) * st_inc);
            ce_down = 1'b0;
            if (k == 1) start = 1'b1;
            tick;
            start = 1'b0;
            check("phase_inc_step", phase_inc, exp_inc);
            last_inc = exp_inc;
            tick;
            if (abort_mode == 1 && k == abort_step) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                check_idle_outputs("abort_settle", exp_inc);
                for (int j = 0; j < 5; j++) begin
                    tick;
                    check("abort_no_done", done, 0);
                end
                return;
            end
            to = 0;
            while (!res_valid && to < 4000) begin
                ce_down = 1'($urandom_range(0, 1));
                if (mag_mode == 0) mag = 100;
                else if (mag_mode == 1) mag = (alt_cnt % 2 == 0) ? -5 : 7;
                else mag = int'($urandom_range(0, 65535)) - 32768;
                rx_magnitude = 16'(mag);
                rx_phase = 25'($urandom);
                if (ce_down) begin
                    mags.push_back(mag);
                    phs.push_back(rx_phase);
                    if (mag_mode == 1) alt_cnt++;
                end
                tick;
                to++;
            end
            ce_down = 1'b0;
            check("emit_reached", res_valid, 1);
            if (!res_valid) return;
            check("strobes_used", 64'(mags.size()), 64'(int'(st) + avg_eff));
            sum = 0;
            for (int i = int'(st); i < int'(st) + avg_eff && i < mags.size(); i++)
                if (mags[i] > 0) sum += mags[i];
            check("res_mag_sum", res_mag_sum, 64'(sum));
            check("res_index", res_index, 64'(k));
`ifdef RX_SWEEP_PHASE_EN
            if (mags.size() >= int'(st) + avg_eff)
                check("res_phase", res_phase, phs[int'(st) + avg_eff - 1]);
`endif
            if (abort_mode == 2 && k == abort_step) begin
                res_ready = 1'b1;
                abort = 1'b1;
                tick;
                res_ready = 1'b0;
                abort = 1'b0;
                check_idle_outputs("abort_emit", exp_inc);
                tick;
                check("abort_emit_no_done", done, 0);
                return;
            end
            hold = toggle_hold ? hold_max : $urandom_range(0, hold_max);
            stable = 1'b1;
            for (int j = 0; j < hold; j++) begin
                if (toggle_hold) begin
                    ce_down = 1'(j % 2);
                    rx_magnitude = 16'h7fff;
                end
                tick;
                if (!(res_valid && res_mag_sum == 28'(sum) && res_index == 16'(k)))
                    stable = 1'b0;
            end
            ce_down = 1'b0;
            check("result_held", stable, 1);
            check("hold_sum", res_mag_sum, 64'(sum));
            res_ready = 1'b1;
            tick;
            res_ready = 1'b0;
            check("valid_dropped", res_valid, 0);
            if (k == int'(n) - 1) begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 0);
                tick;
                check("done_single", done, 0);
                check("idle_busy", busy, 0);
                check("final_phase_inc", phase_inc, exp_inc);
            end else begin
                check("busy_between", busy, 1);
            end
        end
    endtask

    initial begin
        int seen;
        bit bad_valid;
        // Reset state
        tick;
        tick;
        rst = 1'b0;
        check_idle_outputs("reset", 24'h0);
        check("reset_res_index", res_index, 0);
        check("reset_res_mag_sum", res_mag_sum, 0);
`ifdef RX_SWEEP_PHASE_EN
        check("reset_res_phase", res_phase, 0);
`endif
        tick;

        // Basic three-step sweep, constant magnitude
        run_sweep(24'h010000, 24'h000100, 16'd3, 12'd2, 12'd4, 0, 3, 1'b0, 0, 0);

        // Empty sweep
        num_steps = 16'd0; start_inc = 24'hABCDEF;
        start = 1'b1;
        tick;
        start = 1'b0;
        seen = 0;
        bad_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen++;
            if (res_valid) bad_valid = 1'b1;
            tick;
        end
        check("empty_done_count", 64'(seen), 1);
        check("empty_no_valid", bad_valid, 0);
        check("empty_phase_inc", phase_inc, last_inc);

        // Backpressure with strobes during EMIT
        run_sweep(24'h020000, 24'h000010, 16'd2, 12'd1, 12'd3, 2, 50, 1'b1, 0, 0);

        // Abort in SETTLE of step 1, then a clean sweep
        run_sweep(24'h030000, 24'h000200, 16'd3, 12'd6, 12'd2, 2, 2, 1'b0, 1, 1);
        run_sweep(24'h040000, 24'h001000, 16'd2, 12'd3, 12'd5, 2, 2, 1'b0, 0, 0);

        // avg 0 -> 1, settle 0, alternating -5/+7
        alt_cnt = 0;
        run_sweep(24'h050000, 24'h000040, 16'd4, 12'd0, 12'd0, 1, 1, 1'b0, 0, 0);

        // Phase increment wrap
        run_sweep(24'h000080, 24'hFFFF00, 16'd2, 12'd1, 12'd2, 2, 1, 1'b0, 0, 0);
        check("wrap_phase_inc", phase_inc, 24'hFFFF80);

        // Abort colliding with a handshake
        run_sweep(24'h060000, 24'h000001, 16'd2, 12'd0, 12'd1, 2, 0, 1'b0, 2, 0);

        // start and abort together in IDLE
        num_steps = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        tick;
        check("start_abort_done", done, 0);

        // Random sweeps
        for (int r = 0; r < 4; r++)
            run_sweep(24'($urandom), 24'($urandom), 16'($urandom_range(1, 4)),
                      12'($urandom_range(0, 5)), 12'($urandom_range(0, 6)),
                      2, 3, 1'b0, 0, 0);

        // Reset mid-sweep
        start_inc = 24'h123456; step_inc = 24'h1; num_steps = 16'd5;
        settle_cnt = 12'd10; avg_cnt = 12'd10;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("pre_rst_phase_inc", phase_inc, 24'h123456);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_idle_outputs("mid_rst", 24'h0);
        check("mid_rst_res_mag_sum", res_mag_sum, 0);
        check("mid_rst_res_index", res_index, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
